// File: rtl/cpu_pkg.sv
// +-----------------------------------------------------------------+
// | cpu_pkg : shared types and constants for the program sequencer  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int PC_W_DEFAULT = 10;
  localparam int RESET_VECTOR = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // A one-entry table still needs a one-bit index to be addressable.
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_lut.sv
// +-----------------------------------------------------------------+
// | branch_lut : branch-target table, 1 sync write / 1 comb read     |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module branch_lut
  import cpu_pkg::*;
#(
  parameter int LUT_DEPTH = 32,
  parameter int DATA_W    = PC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [7:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_in_range,
  output logic              wr_in_range
);

  localparam int IDX_W = idx_bits(LUT_DEPTH);

  logic [DATA_W-1:0] mem_q [LUT_DEPTH];
  logic [DATA_W-1:0] mem_d [LUT_DEPTH];

  assign rd_in_range = (int'(raddr) < LUT_DEPTH);
  assign wr_in_range = (int'(waddr) < LUT_DEPTH);

  // Read sees the pre-write contents, so a same-cycle write never leaks into a branch.
  assign rdata = rd_in_range ? mem_q[raddr[IDX_W-1:0]] : '0;

  always_comb begin
    mem_d = mem_q;
    if (we && wr_in_range) begin
      mem_d[waddr[IDX_W-1:0]] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +-----------------------------------------------------------------+
// | pc_sequencer : program counter, branch LUT and run/stall/halt FSM|
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int LUT_DEPTH = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             branch_enable,
  input  logic [7:0]       branch_lut_index,
  input  logic             mem_stall,
  input  logic             lut_we,
  input  logic [7:0]       lut_waddr,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count
);

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PC_W-1:0]  lut_rdata;
  logic             lut_rd_ok;
  logic             lut_wr_ok;

  branch_lut #(
    .LUT_DEPTH (LUT_DEPTH),
    .DATA_W    (PC_W)
  ) u_branch_lut (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (lut_we),
    .waddr       (lut_waddr),
    .wdata       (lut_wdata),
    .raddr       (branch_lut_index),
    .rdata       (lut_rdata),
    .rd_in_range (lut_rd_ok),
    .wr_in_range (lut_wr_ok)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if ((state_q == RUN || state_q == STALL) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = PC_W'(RESET_VECTOR);
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DONE;
        end else if (mem_stall) begin
          // The stalled instruction re-issues, so its branch is re-evaluated later.
          state_d = STALL;
        end else if (branch_enable && lut_rd_ok) begin
          pc_d = lut_rdata;
        end else begin
          pc_d = pc_q + 1'b1;
          if (branch_enable || (pc_q == '1)) begin
            err_d = 1'b1;
          end
        end
      end
      STALL: begin
        if (!mem_stall) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (lut_we && !lut_wr_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(RESET_VECTOR);
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign err         = err_q;
  assign cycle_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// +-----------------------------------------------------------------+
// | tb_pc_sequencer : directed + random checks against a ref model  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_pc_sequencer;

  localparam int DEPTH   = 32;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STALL = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Wide instance: default parameters
  logic       start0, halt0, be0, stall0, we0;
  logic [7:0] idx0, waddr0;
  logic [9:0] wdata0, pc0;
  logic       fv0, done0, err0;
  logic [15:0] cnt0;

  // Narrow instance: 4-bit pc and counter to reach wrap and saturation quickly
  logic       start1, halt1, be1, stall1, we1;
  logic [7:0] idx1, waddr1;
  logic [3:0] wdata1, pc1;
  logic       fv1, done1, err1;
  logic [3:0] cnt1;

  pc_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .halt(halt0),
    .branch_enable(be0), .branch_lut_index(idx0), .mem_stall(stall0),
    .lut_we(we0), .lut_waddr(waddr0), .lut_wdata(wdata0),
    .pc(pc0), .fetch_valid(fv0), .done(done0), .err(err0), .cycle_count(cnt0)
  );

  pc_sequencer #(.PC_W(4), .LUT_DEPTH(DEPTH), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .halt(halt1),
    .branch_enable(be1), .branch_lut_index(idx1), .mem_stall(stall1),
    .lut_we(we1), .lut_waddr(waddr1), .lut_wdata(wdata1),
    .pc(pc1), .fetch_valid(fv1), .done(done1), .err(err1), .cycle_count(cnt1)
  );

  int tests = 0;
  int fails = 0;

  int m_mode [2];
  int m_pc   [2];
  int m_err  [2];
  int m_cnt  [2];
  int m_lut  [2][DEPTH];
  int pc_top [2] = '{1023, 15};
  int cnt_top[2] = '{65535, 15};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i, input bit rn, input bit st, input bit hl,
                            input bit br, input int idx, input bit sl, input bit we,
                            input int wa, input int wd);
    int nmode, npc, nerr, ncnt;
    if (!rn) begin
      m_mode[i] = M_IDLE; m_pc[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
      for (int k = 0; k < DEPTH; k++) m_lut[i][k] = 0;
      return;
    end
    nmode = m_mode[i]; npc = m_pc[i]; nerr = m_err[i]; ncnt = m_cnt[i];
    if (m_mode[i] == M_RUN || m_mode[i] == M_STALL)
      ncnt = (m_cnt[i] < cnt_top[i]) ? m_cnt[i] + 1 : cnt_top[i];
    case (m_mode[i])
      M_IDLE: if (st) begin nmode = M_RUN; npc = 0; ncnt = 0; nerr = 0; end
      M_RUN: begin
        if (hl) nmode = M_DONE;
        else if (sl) nmode = M_STALL;
        else if (br && idx < DEPTH) npc = m_lut[i][idx];
        else begin
          npc = (m_pc[i] + 1) % (pc_top[i] + 1);
          if (br || m_pc[i] == pc_top[i]) nerr = 1;
        end
      end
      M_STALL: if (!sl) nmode = M_RUN;
      default: if (!st) nmode = M_IDLE;
    endcase
    if (we) begin
      if (wa < DEPTH) m_lut[i][wa] = wd;
      else nerr = 1;
    end
    m_mode[i] = nmode; m_pc[i] = npc; m_err[i] = nerr; m_cnt[i] = ncnt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, rst_n, start0, halt0, be0, int'(idx0), stall0, we0, int'(waddr0), int'(wdata0));
    model_step(1, rst_n, start1, halt1, be1, int'(idx1), stall1, we1, int'(waddr1), int'(wdata1));
    #1;
    chk("pc0",   pc0,   m_pc[0]);
    chk("fv0",   fv0,   m_mode[0] == M_RUN);
    chk("done0", done0, m_mode[0] == M_DONE);
    chk("err0",  err0,  m_err[0]);
    chk("cnt0",  cnt0,  m_cnt[0]);
    chk("pc1",   pc1,   m_pc[1]);
    chk("fv1",   fv1,   m_mode[1] == M_RUN);
    chk("done1", done1, m_mode[1] == M_DONE);
    chk("err1",  err1,  m_err[1]);
    chk("cnt1",  cnt1,  m_cnt[1]);
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 0; halt0 = 0; be0 = 0; stall0 = 0; we0 = 0; idx0 = 0; waddr0 = 0; wdata0 = 0;
    start1 = 0; halt1 = 0; be1 = 0; stall1 = 0; we1 = 0; idx1 = 0; waddr1 = 0; wdata1 = 0;
    tick(); tick();
    chk("reset_pc", pc0, 0);
    chk("reset_fv", fv0, 0);

    // Reset in the middle of a run
    rst_n = 1'b1; start0 = 1; tick();
    repeat (4) tick();
    rst_n = 1'b0; start0 = 0; tick();
    chk("midrst_pc", pc0, 0);
    chk("midrst_fv", fv0, 0);
    chk("midrst_cnt", cnt0, 0);
    rst_n = 1'b1; tick();
    start1 = 1;

    // Sequential run then halt
    start0 = 1; tick();
    chk("seq_pc0", pc0, 0);
    chk("seq_fv", fv0, 1);
    repeat (4) tick();
    chk("seq_pc4", pc0, 4);
    halt0 = 1; tick();
    chk("halt_done", done0, 1);
    chk("halt_cnt", cnt0, 5);
    chk("halt_pc", pc0, 4);
    halt0 = 0; tick();
    chk("done_held", done0, 1);
    start0 = 0; tick();
    chk("idle_done", done0, 0);

    // Branch, including same-cycle write to the taken entry
    we0 = 1; waddr0 = 3; wdata0 = 10'h40; tick();
    we0 = 0; start0 = 1; tick();
    tick(); tick();
    chk("br_pre_pc", pc0, 2);
    be0 = 1; idx0 = 3; we0 = 1; waddr0 = 3; wdata0 = 10'h80; tick();
    chk("br_old", pc0, 10'h40);
    we0 = 0; be0 = 0; tick();
    be0 = 1; tick();
    chk("br_new", pc0, 10'h80);

    // Stall outranks a simultaneous branch
    be0 = 0; we0 = 1; waddr0 = 4; wdata0 = 7; tick();
    we0 = 0; be0 = 1; idx0 = 4; tick();
    chk("stall_pre", pc0, 7);
    idx0 = 3; stall0 = 1; tick();
    chk("stall_pc_a", pc0, 7);
    chk("stall_fv_a", fv0, 0);
    tick();
    chk("stall_pc_b", pc0, 7);
    stall0 = 0; tick();
    chk("refetch_pc", pc0, 7);
    chk("refetch_fv", fv0, 1);
    tick();
    chk("post_stall_br", pc0, 10'h80);
    be0 = 0;

    // Narrow instance has been running long enough to wrap and saturate
    chk("narrow_cnt_sat", cnt1, 15);
    chk("narrow_wrap_err", err1, 1);

    // Out-of-range branch index
    halt0 = 1; tick();
    halt0 = 0; start0 = 0; tick();
    start0 = 1; tick();
    repeat (5) tick();
    chk("bad_pre_pc", pc0, 5);
    chk("bad_pre_err", err0, 0);
    be0 = 1; idx0 = 40; tick();
    chk("bad_idx_pc", pc0, 6);
    chk("bad_idx_err", err0, 1);
    be0 = 0; tick(); tick();
    chk("err_sticky", err0, 1);

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      start0 = ($urandom_range(0, 3) != 0);
      halt0  = ($urandom_range(0, 15) == 0);
      be0    = ($urandom_range(0, 3) == 0);
      idx0   = 8'($urandom_range(0, 47));
      stall0 = ($urandom_range(0, 4) == 0);
      we0    = ($urandom_range(0, 3) == 0);
      waddr0 = 8'($urandom_range(0, 39));
      wdata0 = 10'($urandom);
      start1 = ($urandom_range(0, 3) != 0);
      halt1  = ($urandom_range(0, 15) == 0);
      be1    = ($urandom_range(0, 3) == 0);
      idx1   = 8'($urandom_range(0, 47));
      stall1 = ($urandom_range(0, 4) == 0);
      we1    = ($urandom_range(0, 3) == 0);
      waddr1 = (($urandom_range(0, 19) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31)));
      wdata1 = 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
